sub_bytes_shift_rows: RTL and testbench
=======================================

# sub_bytes_shift_rows

Iterative AES SubBytes + ShiftRows stage for the ALU's AES round datapath. Accepts a 128-bit state over a valid/ready handshake and substitutes SBOX_LANES bytes per cycle through a shared forward S-box. It then presents the ShiftRows-permuted result on an output valid/ready handshake. Sits directly upstream of the MixColumns stage and feeds its 128-bit state input.

## Interface
- SBOX_LANES, default 4: number of S-box instances, i.e. bytes substituted per cycle. Legal values are 1, 2, 4, 8 and 16. N_CYC = 16/SBOX_LANES.
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  state_in holds a valid block.
- in_ready  output  1  the block can accept a new state this cycle.
- state_in  input  128  input state.
- out_valid  output  1  state_out holds a finished block.
- out_ready  input  1  the downstream stage accepts state_out this cycle.
- state_out  output  128  ShiftRows(SubBytes(state_in)).
- busy  output  1  high in SUB and DONE.

## Operation
- Byte order: byte i = state[127-8i -: 8], with i = r + 4c (row r, column c, column-major as in FIPS-197).
- SubBytes: each byte b becomes S(b), using the FIPS-197 forward S-box. The S-box is implemented as a combinational lookup function, one instance per lane.
- ShiftRows: out byte (r + 4c) = sub byte (r + 4·((c + r) mod 4)). It is pure wiring from the internal buffer to state_out.
- Internal registers:
  - buf[127:0], the working state;
  - cnt, a chunk index of ceil(log2(N_CYC)) bits, minimum 1 bit;
  - fsm.
- FSM states:
  - IDLE: in_ready = 1. On in_valid, capture buf <= state_in, set cnt <= 0, go to SUB.
  - SUB: each cycle replace bytes cnt·SBOX_LANES .. cnt·SBOX_LANES+SBOX_LANES-1 of buf with their S-box images, then increment cnt. On the cycle with cnt = N_CYC-1, go to DONE. in_ready = 0.
  - DONE: out_valid = 1 and state_out is stable. On out_ready:
    - if in_valid is also high, capture the new state_in, set cnt <= 0, go to SUB (back-to-back);
    - otherwise go to IDLE.
- in_ready = rst_n & (fsm == IDLE | (fsm == DONE & out_ready)). The combinational path from out_ready to in_ready is intentional.
- in_valid is ignored outside the accepting condition; state_in is not sampled.
- SBOX_LANES = 16: SUB lasts exactly one cycle, with cnt held at 0.
- Reset, asynchronous and possibly mid-operation:
  - fsm = IDLE, cnt = 0, buf = 0;
  - out_valid = 0, busy = 0;
  - in_ready = 0 while rst_n is low, 1 after release;
  - state_out = ShiftRows(0) = 0;
  - any block in flight is discarded and never emitted.

## Timing
- Latency: a block accepted at edge k has out_valid high after edge k + N_CYC. That is 4 cycles for SBOX_LANES = 4, and 1 cycle for 16.
- Throughput with out_ready held high is one block per N_CYC + 1 cycles; the back-to-back accept in DONE saves the IDLE cycle.
- out_valid stays high and state_out stays unchanged until the cycle in which out_ready = 1; they drop on the following edge unless a new block completes.
- Bytes are processed in index order, so chunk j covers bytes j·SBOX_LANES and up.
- No combinational path exists from state_in to state_out; all outputs except in_ready are register-driven.

## Test plan
- Reset, then FIPS-197 Appendix B round-1 state. With SBOX_LANES = 4, pulse in_valid with state_in = 0x193de3bea0f4e22b9ac68d2ae9f84808 and hold out_ready = 1.
  - out_valid rises 4 cycles after the accept edge.
  - state_out = 0xd4bf5d30e0b452aeb84111f11e2798e5.
- Backpressure: same block with out_ready = 0 for 10 cycles.
  - out_valid and state_out stay stable throughout.
  - in_ready stays 0.
  - Exactly one transfer occurs when out_ready rises.
- Back-to-back: drive the all-zero state with in_valid held high and out_ready = 1.
  - The second block is accepted in the same cycle the first is consumed.
  - Each output is 0x63636363636363636363636363636363.
  - Block period is 5 cycles.
- Parameter sweep: repeat the first scenario for SBOX_LANES = 1, 2, 8, 16.
  - Latency is 16, 8, 2, 1 cycles respectively.
  - Output value is identical in every case.
- Reset mid-SUB: assert rst_n low in cycle 2 of SUB.
  - out_valid = 0, busy = 0, state_out = 0 immediately, without waiting for a clock edge.
  - After release, in_ready = 1 and no stale block is ever emitted.
- Randomised compare against a reference model: 1000 random states with random in_valid/out_ready stalls.
  - Outputs match in order with no loss or duplication.

Source files
------------

// File: rtl/sub_bytes_shift_rows.sv
// Iterative AES SubBytes + ShiftRows stage: SBOX_LANES bytes substituted per cycle,
// ShiftRows applied as wiring on the output of the working buffer.
module sub_bytes_shift_rows #(
    parameter int SBOX_LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy
);

    localparam int N_CYC = 16 / SBOX_LANES;
    localparam int CNT_W = (N_CYC > 1) ? $clog2(N_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_CYC - 1);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    typedef enum logic [1:0] {IDLE, SUB, DONE} fsm_t;

    fsm_t           fsm;
    fsm_t           fsm_next;
    logic [127:0]   state_buf;
    logic [127:0]   sub_buf;
    logic [CNT_W-1:0] cnt;
    logic           accept;

    // Only the current chunk of SBOX_LANES bytes passes through the S-box lanes.
    always_comb begin
        int idx;
        idx     = 0;
        sub_buf = state_buf;
        for (int l = 0; l < SBOX_LANES; l++) begin
            idx = int'(cnt) * SBOX_LANES + l;
            sub_buf[127 - 8*idx -: 8] = sbox(state_buf[127 - 8*idx -: 8]);
        end
    end

    always_comb begin
        in_ready = rst_n & ((fsm == IDLE) | ((fsm == DONE) & out_ready));
        accept   = in_valid & in_ready;
        fsm_next = fsm;
        case (fsm)
            IDLE:    if (accept) fsm_next = SUB;
            SUB:     if (cnt == CNT_LAST) fsm_next = DONE;
            DONE:    if (out_ready) fsm_next = accept ? SUB : IDLE;
            default: fsm_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm       <= IDLE;
            cnt       <= '0;
            state_buf <= '0;
        end else begin
            fsm <= fsm_next;
            if (accept) begin
                state_buf <= state_in;
                cnt       <= '0;
            end else if (fsm == SUB) begin
                state_buf <= sub_buf;
                cnt       <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
            end
        end
    end

    assign out_valid = (fsm == DONE);
    assign busy      = (fsm != IDLE);

    // ShiftRows: row r rotates left by r columns.
    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < 4; c++) begin : g_col
            assign state_out[127 - 8*(r + 4*c) -: 8] = state_buf[127 - 8*(r + 4*((c + r) % 4)) -: 8];
        end
    end

endmodule

// File: tb/tb_sub_bytes_shift_rows.sv
// Bench for sub_bytes_shift_rows: one instance per legal lane count, a scoreboard fed from
// an algebraic S-box model (GF(2^8) inverse + affine map), directed and random traffic.
module tb_sub_bytes_shift_rows;

    localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] ZERO_OUT = 128'h63636363636363636363636363636363;

    logic         clk;
    logic         rst_n;
    logic [127:0] state_in;
    logic [4:0]   in_valid;
    logic [4:0]   out_ready;
    logic         in_ready  [5];
    logic         out_valid [5];
    logic         busy      [5];
    logic [127:0] state_out [5];

    for (genvar k = 0; k < 5; k++) begin : g_dut
        sub_bytes_shift_rows #(.SBOX_LANES(1 << k)) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[k]),
            .in_ready  (in_ready[k]),
            .state_in  (state_in),
            .out_valid (out_valid[k]),
            .out_ready (out_ready[k]),
            .state_out (state_out[k]),
            .busy      (busy[k])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int           n_compared;
    int           n_mismatched;
    int           sel;
    int           cyc;
    int           n_accepted;
    int           n_xfer;
    int           n_b2b;
    int           last_accept_edge;
    logic [127:0] last_out;
    logic [127:0] sb_q [$];
    int           xfer_edges [$];
    logic [7:0]   ref_sbox [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic       hi;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = a << 1;
            if (hi) a = a ^ 8'h1b;
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] w;
        w = {x, x} << n;
        return w[15:8];
    endfunction

    function automatic logic [127:0] ref_model(input logic [127:0] s);
        logic [7:0]   sb [16];
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) sb[i] = ref_sbox[s[127 - 8*i -: 8]];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[127 - 8*(r + 4*c) -: 8] = sb[r + 4*((c + r) % 4)];
        return o;
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        n_compared++;
        assert (observed === expected)
        else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int k, input logic iv, input logic ordy, input logic [127:0] data);
        in_valid[k]  = iv;
        out_ready[k] = ordy;
        state_in     = data;
    endtask

    // One clock: handshakes of the selected instance are sampled mid-cycle, then the edge.
    task automatic step();
        logic acc;
        logic xf;
        @(negedge clk);
        acc = in_valid[sel] && in_ready[sel];
        xf  = out_valid[sel] && out_ready[sel];
        if (acc) begin
            sb_q.push_back(ref_model(state_in));
            n_accepted++;
            last_accept_edge = cyc;
        end
        if (xf) begin
            checkOutput("sb_output_expected", {127'd0, sb_q.size() != 0}, 128'd1);
            if (sb_q.size() != 0) checkOutput("sb_data", state_out[sel], sb_q.pop_front());
            last_out = state_out[sel];
            xfer_edges.push_back(cyc);
            n_xfer++;
            if (acc) n_b2b++;
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic run_single(input int k, input logic [127:0] data, input logic [127:0] expected);
        sel = k;
        xfer_edges.delete();
        applyStimulus(k, 1'b1, 1'b1, data);
        step();
        applyStimulus(k, 1'b0, 1'b1, data);
        for (int i = 0; i < 40 && sb_q.size() != 0; i++) step();
        checkOutput($sformatf("sweep%0d_drained", k), 128'(sb_q.size()), 128'd0);
        checkOutput($sformatf("sweep%0d_latency", k),
                    128'(xfer_edges.size() != 0 ? xfer_edges[0] - last_accept_edge - 1 : -1),
                    128'(16 >> k));
        checkOutput($sformatf("sweep%0d_value", k), last_out, expected);
    endtask

    initial begin
        logic [127:0] held;
        int           x0;
        int           acc0;
        logic [127:0] rnd;

        n_compared = 0; n_mismatched = 0; cyc = 0; sel = 2;
        n_accepted = 0; n_xfer = 0; n_b2b = 0; last_accept_edge = 0; last_out = '0;
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            ref_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end

        rst_n = 1'b0; in_valid = '0; out_ready = '1; state_in = '0;
        #1;
        checkOutput("reset_in_ready_low", {127'd0, in_ready[2]}, 128'd0);
        checkOutput("reset_out_valid", {127'd0, out_valid[2]}, 128'd0);
        checkOutput("reset_busy", {127'd0, busy[2]}, 128'd0);
        checkOutput("reset_state_out", state_out[2], 128'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        checkOutput("release_in_ready", {127'd0, in_ready[2]}, 128'd1);

        $display("[TB] FIPS-197 round-1 vector, 4 lanes");
        run_single(2, FIPS_IN, FIPS_OUT);

        $display("[TB] backpressure");
        sel = 2;
        applyStimulus(2, 1'b1, 1'b0, FIPS_IN);
        step();
        applyStimulus(2, 1'b0, 1'b0, FIPS_IN);
        for (int i = 0; i < 20 && !out_valid[2]; i++) step();
        checkOutput("bp_out_valid_rose", {127'd0, out_valid[2]}, 128'd1);
        held = state_out[2];
        checkOutput("bp_value", held, FIPS_OUT);
        for (int i = 0; i < 10; i++) begin
            checkOutput("bp_hold_valid", {127'd0, out_valid[2]}, 128'd1);
            checkOutput("bp_hold_data", state_out[2], held);
            checkOutput("bp_in_ready", {127'd0, in_ready[2]}, 128'd0);
            step();
        end
        x0 = n_xfer;
        applyStimulus(2, 1'b0, 1'b1, FIPS_IN);
        step();
        step();
        checkOutput("bp_one_transfer", 128'(n_xfer - x0), 128'd1);
        checkOutput("bp_valid_dropped", {127'd0, out_valid[2]}, 128'd0);

        $display("[TB] back-to-back zero blocks");
        xfer_edges.delete();
        x0 = n_b2b;
        applyStimulus(2, 1'b1, 1'b1, 128'd0);
        for (int i = 0; i < 40 && xfer_edges.size() < 3; i++) step();
        applyStimulus(2, 1'b0, 1'b1, 128'd0);
        for (int i = 0; i < 40 && sb_q.size() != 0; i++) step();
        checkOutput("b2b_transfers", 128'(xfer_edges.size()), 128'd4);
        checkOutput("b2b_same_cycle_accepts", 128'(n_b2b - x0), 128'd3);
        checkOutput("b2b_period_1", 128'(xfer_edges.size() >= 2 ? xfer_edges[1] - xfer_edges[0] : 0), 128'd5);
        checkOutput("b2b_period_2", 128'(xfer_edges.size() >= 3 ? xfer_edges[2] - xfer_edges[1] : 0), 128'd5);
        checkOutput("b2b_value", last_out, ZERO_OUT);

        $display("[TB] lane sweep");
        for (int k = 0; k < 5; k++) run_single(k, FIPS_IN, FIPS_OUT);

        $display("[TB] reset in the middle of SUB");
        sel = 2;
        x0 = n_xfer;
        applyStimulus(2, 1'b1, 1'b1, FIPS_IN);
        step();
        applyStimulus(2, 1'b0, 1'b1, FIPS_IN);
        step();
        checkOutput("mid_busy_before", {127'd0, busy[2]}, 128'd1);
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        checkOutput("mid_out_valid", {127'd0, out_valid[2]}, 128'd0);
        checkOutput("mid_busy", {127'd0, busy[2]}, 128'd0);
        checkOutput("mid_state_out", state_out[2], 128'd0);
        checkOutput("mid_in_ready_low", {127'd0, in_ready[2]}, 128'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        checkOutput("mid_in_ready_release", {127'd0, in_ready[2]}, 128'd1);
        for (int i = 0; i < 20; i++) step();
        checkOutput("mid_no_stale_output", 128'(n_xfer - x0), 128'd0);

        $display("[TB] random traffic, 1000 blocks");
        sel = 2;
        acc0 = n_accepted;
        x0 = n_xfer;
        for (int i = 0; i < 40000 && ((n_accepted - acc0) < 1000 || sb_q.size() != 0); i++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom};
            applyStimulus(2, ((n_accepted - acc0) < 1000) && ($urandom_range(0, 3) != 0),
                          $urandom_range(0, 3) != 0, rnd);
            step();
        end
        applyStimulus(2, 1'b0, 1'b1, '0);
        checkOutput("rand_accepted", 128'(n_accepted - acc0), 128'd1000);
        checkOutput("rand_transferred", 128'(n_xfer - x0), 128'd1000);
        checkOutput("rand_queue_empty", 128'(sb_q.size()), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
